// File: rtl/vga_line_engine_pkg.sv
// Shared line-timing state encoding and default 1792-clock line timing.
package vga_line_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_BP,
    ST_ACT,
    ST_FP
  } state_e;

  localparam int DEF_H_SYNC   = 192;
  localparam int DEF_H_BP     = 96;
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 224;

  // Counter width that stays legal for degenerate (1-value) ranges.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/vga_pixel_shifter.sv
// Prefetch + shift register pair that replays each source pixel SCALE clocks.
module vga_pixel_shifter
  import vga_line_engine_pkg::*;
#(
  parameter int SCALE        = 5,
  parameter int PIX_PER_WORD = 32,
  parameter int BPC          = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr_i,
  input  logic                          act_i,
  input  logic                          first_i,
  input  logic                          rd_vld_i,
  input  logic [PIX_PER_WORD*3*BPC-1:0] rd_data_i,
  output logic                          load_o,
  output logic [3*BPC-1:0]              pix_o
);

  localparam int CW     = 3 * BPC;
  localparam int DW     = PIX_PER_WORD * CW;
  localparam int SUB_W  = clog2_min1(SCALE);
  localparam int SLOT_W = clog2_min1(PIX_PER_WORD);

  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DW-1:0]     sh_q, sh_d, pf_q, pf_d, src;

  // A word arriving on the very clock it is needed bypasses the prefetch register.
  assign src = rd_vld_i ? rd_data_i : pf_q;

  always_comb begin
    sub_d  = sub_q;
    slot_d = slot_q;
    sh_d   = sh_q;
    pf_d   = pf_q;
    load_o = 1'b0;
    if (act_i) begin
      if (first_i || sub_q == SUB_W'(SCALE - 1)) begin
        sub_d  = '0;
        slot_d = (first_i || slot_q == SLOT_W'(PIX_PER_WORD - 1)) ? '0 : slot_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
      if (sub_d == '0) begin
        if (slot_d == '0) begin
          load_o = 1'b1;
          sh_d   = src;
        end else begin
          sh_d = sh_q >> CW;
        end
      end
    end
    if (rd_vld_i && !load_o) pf_d = rd_data_i;
    if (clr_i) begin
      sub_d  = '0;
      slot_d = '0;
      sh_d   = '0;
      pf_d   = '0;
      load_o = 1'b0;
    end
  end

  assign pix_o = sh_d[CW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_q  <= '0;
      slot_q <= '0;
      sh_q   <= '0;
      pf_q   <= '0;
    end else begin
      sub_q  <= sub_d;
      slot_q <= slot_d;
      sh_q   <= sh_d;
      pf_q   <= pf_d;
    end
  end

endmodule

// File: rtl/vga_line_engine.sv
// Horizontal line timing, memory word fetch and pixel/colour-bar output for one scanline.
module vga_line_engine
  import vga_line_engine_pkg::*;
#(
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int SCALE        = 5,
  parameter int PIX_PER_WORD = 32,
  parameter int BPC          = 1,
  parameter int ADDR_W       = 14,
  parameter bit SYNC_POL     = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          line_en,
  input  logic                          pattern_en,
  input  logic [ADDR_W-1:0]             base_addr,
  output logic                          rd_req,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [PIX_PER_WORD*3*BPC-1:0] rd_data,
  output logic                          h_sync,
  output logic                          de,
  output logic [BPC-1:0]                red,
  output logic [BPC-1:0]                green,
  output logic [BPC-1:0]                blue,
  output logic                          line_done
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int A_START = H_SYNC + H_BP;
  localparam int NWORDS  = H_ACTIVE / (SCALE * PIX_PER_WORD);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int NW      = clog2_min1(H_TOTAL + 1);
  localparam int WW      = clog2_min1(NWORDS + 1);
  localparam int BCW     = clog2_min1(BAR_W);

  localparam logic [NW-1:0]  N_BP    = NW'(H_SYNC);
  localparam logic [NW-1:0]  N_ACT   = NW'(A_START);
  localparam logic [NW-1:0]  N_FP    = NW'(A_START + H_ACTIVE);
  localparam logic [NW-1:0]  N_LAST  = NW'(H_TOTAL - 1);
  localparam logic [BCW-1:0] BAR_END = BCW'(BAR_W - 1);

  state_e             state_q, state_d;
  logic [NW-1:0]      n_q, n_d;
  logic [ADDR_W-1:0]  base_q, rd_addr_q, rd_addr_d;
  logic               pat_q, pend_q;
  logic               rd_req_q, rd_req_d;
  logic [WW-1:0]      wreq_q, wreq_d;
  logic [BCW-1:0]     bar_cnt_q, bar_cnt_d;
  logic [2:0]         bar_q, bar_d;
  logic [3*BPC-1:0]   rgb_q, rgb_d, pix;
  logic               hs_q, de_q, done_q;
  logic               line_start, first_pix, act, load, clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Line position and phase both derive from the clock about to be entered (n_d).
  always_comb begin
    n_d     = '0;
    state_d = ST_IDLE;
    if (line_en) begin
      if (state_q != ST_IDLE && n_q != N_LAST) n_d = n_q + 1'b1;
      if (n_d < N_BP)       state_d = ST_SYNC;
      else if (n_d < N_ACT) state_d = ST_BP;
      else if (n_d < N_FP)  state_d = ST_ACT;
      else                  state_d = ST_FP;
    end
  end

  assign line_start = line_en && (n_d == '0);
  assign first_pix  = line_en && (n_d == N_ACT);
  assign act        = (state_d == ST_ACT);
  assign clr        = !line_en;

  vga_pixel_shifter #(
    .SCALE       (SCALE),
    .PIX_PER_WORD(PIX_PER_WORD),
    .BPC         (BPC)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (clr),
    .act_i    (act),
    .first_i  (first_pix),
    .rd_vld_i (pend_q),
    .rd_data_i(rd_data),
    .load_o   (load),
    .pix_o    (pix)
  );

  always_comb begin
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    wreq_d    = wreq_q;
    bar_cnt_d = bar_cnt_q;
    bar_d     = bar_q;
    rgb_d     = '0;
    // Each word load triggers the fetch of the next one into the prefetch slot.
    if (line_en && !pat_q) begin
      if (n_d == N_BP) begin
        rd_req_d  = 1'b1;
        rd_addr_d = base_q;
        wreq_d    = WW'(1);
      end else if (load && wreq_q < WW'(NWORDS)) begin
        rd_req_d  = 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
        wreq_d    = wreq_q + 1'b1;
      end
    end
    if (first_pix) begin
      bar_cnt_d = '0;
      bar_d     = '0;
    end else if (act) begin
      if (bar_cnt_q == BAR_END) begin
        bar_cnt_d = '0;
        bar_d     = bar_q + 1'b1;
      end else begin
        bar_cnt_d = bar_cnt_q + 1'b1;
      end
    end
    if (act) rgb_d = pat_q ? {{BPC{bar_d[2]}}, {BPC{bar_d[1]}}, {BPC{bar_d[0]}}} : pix;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q       <= '0;
      base_q    <= '0;
      pat_q     <= 1'b0;
      pend_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wreq_q    <= '0;
      bar_cnt_q <= '0;
      bar_q     <= '0;
      rgb_q     <= '0;
      hs_q      <= ~SYNC_POL;
      de_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      n_q <= n_d;
      if (line_start) begin
        base_q <= base_addr;
        pat_q  <= pattern_en;
      end
      pend_q    <= line_en & rd_req_q;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      wreq_q    <= wreq_d;
      bar_cnt_q <= bar_cnt_d;
      bar_q     <= bar_d;
      rgb_q     <= rgb_d;
      hs_q      <= (state_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      de_q      <= act;
      done_q    <= line_en && (n_d == N_LAST);
    end
  end

  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign h_sync    = hs_q;
  assign de        = de_q;
  assign red       = rgb_q[BPC-1:0];
  assign green     = rgb_q[2*BPC-1:BPC];
  assign blue      = rgb_q[3*BPC-1:2*BPC];
  assign line_done = done_q;

endmodule

// File: tb/tb_vga_line_engine.sv
// Scoreboard bench: default-timing engine plus a small SCALE=1 / 2-pixel-word / positive-sync engine.
module tb_vga_line_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        le1 = 1'b0, pe1 = 1'b0, rq1, hs1, de1, ld1, r1, g1, b1;
  logic [13:0] ba1 = '0, ra1;
  logic [95:0] rd1 = '0;
  logic        le2 = 1'b0, pe2 = 1'b0, rq2, hs2, de2, ld2, r2, g2, b2;
  logic [3:0]  ba2 = '0, ra2;
  logic [5:0]  rd2 = '0;

  vga_line_engine dut1 (
    .clk(clk), .reset(reset), .line_en(le1), .pattern_en(pe1), .base_addr(ba1),
    .rd_req(rq1), .rd_addr(ra1), .rd_data(rd1), .h_sync(hs1), .de(de1),
    .red(r1), .green(g1), .blue(b1), .line_done(ld1)
  );

  vga_line_engine #(
    .H_SYNC(4), .H_BP(2), .H_ACTIVE(16), .H_FP(3), .SCALE(1), .PIX_PER_WORD(2),
    .BPC(1), .ADDR_W(4), .SYNC_POL(1'b1)
  ) dut2 (
    .clk(clk), .reset(reset), .line_en(le2), .pattern_en(pe2), .base_addr(ba2),
    .rd_req(rq2), .rd_addr(ra2), .rd_data(rd2), .h_sync(hs2), .de(de2),
    .red(r2), .green(g2), .blue(b2), .line_done(ld2)
  );

  typedef struct packed {
    logic [31:0] t;
    logic [31:0] v;
  } ev_t;

  ev_t rdq[2][$];
  ev_t pxq[2][$];
  ev_t syq[2][$];
  ev_t dnq[2][$];

  int HS[2]   = '{192, 4};
  int BP[2]   = '{96, 2};
  int HA[2]   = '{1280, 16};
  int FP[2]   = '{224, 3};
  int SC[2]   = '{5, 1};
  int PW[2]   = '{32, 2};
  int MASK[2] = '{32'h3FFF, 32'hF};

  int  tick = 0;
  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;
  bit  hs_prev[2] = '{1'b0, 1'b0};
  int  hs_start[2] = '{0, 0};

  always @(posedge clk) tick <= tick + 1;

  // Memory: each channel bit of slot s carries bit s of the word address.
  function automatic logic [95:0] mem1(input logic [13:0] a);
    logic [31:0] x;
    x = {18'b0, a};
    mem1 = '0;
    for (int s = 0; s < 32; s++) mem1[s*3 +: 3] = {3{x[s]}};
  endfunction

  always @(posedge clk) begin
    if (rq1) rd1 <= mem1(ra1);
    if (rq2) rd2 <= {{3{ra2[1]}}, {3{ra2[0]}}};
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d tick %0d: got %0h expected %0h", nm, d + 1, tick, act, exp);
    end
  endtask

  task automatic push_line(input int d, input int t0, input int cut, input int base, input bit pat);
    ev_t e;
    int  a0, sp, n, p, a;
    a0 = HS[d] + BP[d];
    sp = SC[d] * PW[d];
    e.t = t0; e.v = t0 + HS[d] - 1;
    syq[d].push_back(e);
    for (int w = 0; w < HA[d] / sp; w++) begin
      n = (w == 0) ? HS[d] : a0 + (w - 1) * sp;
      if (!pat && n <= cut) begin
        e.t = t0 + n; e.v = (base + w) & MASK[d];
        rdq[d].push_back(e);
      end
    end
    for (int i = 0; i < HA[d]; i++) begin
      if (a0 + i <= cut) begin
        p = i / SC[d];
        a = (base + p / PW[d]) & MASK[d];
        e.t = t0 + a0 + i;
        e.v = pat ? i / (HA[d] / 8) : ((((a >> (p % PW[d])) & 1) != 0) ? 7 : 0);
        pxq[d].push_back(e);
      end
    end
    n = a0 + HA[d] + FP[d] - 1;
    if (n <= cut) begin
      e.t = t0 + n; e.v = 0;
      dnq[d].push_back(e);
    end
  endtask

  task automatic mon(input int d, input logic req, input logic [31:0] addr, input logic dv,
                     input logic [31:0] rgb, input logic hsa, input logic done);
    ev_t e;
    if (req) begin
      chk("rd_expected", d, 32'(rdq[d].size() != 0), 1);
      if (rdq[d].size() != 0) begin
        e = rdq[d].pop_front();
        chk("rd_tick", d, tick, e.t);
        chk("rd_addr", d, addr, e.v);
      end
    end
    if (dv) begin
      chk("pix_expected", d, 32'(pxq[d].size() != 0), 1);
      if (pxq[d].size() != 0) begin
        e = pxq[d].pop_front();
        chk("pix_tick", d, tick, e.t);
        chk("pix_rgb", d, rgb, e.v);
      end
    end else begin
      chk("blank_rgb", d, rgb, 0);
    end
    if (hsa && !hs_prev[d]) hs_start[d] = tick;
    if (!hsa && hs_prev[d]) begin
      chk("sync_expected", d, 32'(syq[d].size() != 0), 1);
      if (syq[d].size() != 0) begin
        e = syq[d].pop_front();
        chk("sync_start", d, hs_start[d], e.t);
        chk("sync_end", d, tick - 1, e.v);
      end
    end
    hs_prev[d] = hsa;
    if (done) begin
      chk("done_expected", d, 32'(dnq[d].size() != 0), 1);
      if (dnq[d].size() != 0) begin
        e = dnq[d].pop_front();
        chk("done_tick", d, tick, e.t);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, rq1, 32'(ra1), de1, {29'b0, b1, g1, r1}, hs1 == 1'b0, ld1);
      mon(1, rq2, 32'(ra2), de2, {29'b0, b2, g2, r2}, hs2 == 1'b1, ld2);
    end
  end

  // Runs one dut1 line; base/pattern are scrambled after cycle 0 to show they are sampled only there.
  task automatic run1(input logic [13:0] b, input bit p, input int cut);
    int t0;
    ba1 = b; pe1 = p; le1 = 1'b1;
    t0 = tick + 1;
    push_line(0, t0, cut, b, p);
    @(negedge clk);
    ba1 = b ^ 14'h1555; pe1 = ~p;
    repeat (cut) @(negedge clk);
    le1 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    chk("rst_hsync", 0, hs1, 1);
    chk("rst_de", 0, de1, 0);
    chk("rst_rgb", 0, {b1, g1, r1}, 0);
    chk("rst_rdreq", 0, rq1, 0);
    chk("rst_rdaddr", 0, ra1, 0);
    chk("rst_done", 0, ld1, 0);
    chk("rst_hsync", 1, hs2, 0);
    chk("rst_de", 1, de2, 0);
    chk("rst_rdreq", 1, rq2, 0);
    chk("rst_rdaddr", 1, ra2, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    run1(14'h0100, 1'b0, 1791);
    run1(14'h0001, 1'b0, 1791);
    run1(14'h0000, 1'b1, 1791);
    run1(14'h0000, 1'b0, 700);
    run1(14'h3FFC, 1'b0, 1791);

    // Two back-to-back lines on dut2: data line wrapping the address, then a pattern line.
    ba2 = 4'hE; pe2 = 1'b0; le2 = 1'b1;
    t0 = tick + 1;
    push_line(1, t0, 24, 32'hE, 1'b0);
    push_line(1, t0 + 25, 24, 32'h3, 1'b1);
    @(negedge clk);
    ba2 = 4'h3; pe2 = 1'b1;
    repeat (49) @(negedge clk);
    le2 = 1'b0;
    repeat (8) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk("rdq_left", d, rdq[d].size(), 0);
      chk("pxq_left", d, pxq[d].size(), 0);
      chk("syq_left", d, syq[d].size(), 0);
      chk("dnq_left", d, dnq[d].size(), 0);
      chk("sync_idle_end", d, 32'(hs_prev[d]), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
